// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants and state type for the 4:1 round-robin mux arbiter
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;
    localparam int CNT_W   = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux4_bus.sv
// rtl/mux4_bus.sv - DW-bit 4:1 combinational data mux steered by sel
module mux4_bus #(
    parameter int DW = 8
) (
    input  logic [4*DW-1:0] data,
    input  logic [1:0]      sel,
    output logic [DW-1:0]   y
);

    // Pick the lane addressed by sel; lane k lives at [k*DW +: DW].
    always_comb begin
        y = '0;
        case (sel)
            2'd0:    y = data[0*DW +: DW];
            2'd1:    y = data[1*DW +: DW];
            2'd2:    y = data[2*DW +: DW];
            default: y = data[3*DW +: DW];
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - packet round-robin arbiter for a shared 4:1 mux (optional MUX_ARB_PRIO0_EN)
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DW       = 8,
    parameter int HOLD_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   last,
    input  logic [NUM_REQ*DW-1:0] data_in,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [SEL_W-1:0]     sel,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_MAX);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] winner;
    logic [DW-1:0]    mux_y;
    logic             xfer;
    logic             release_now;

    // First asserted request scanning from p upward, wrapping mod 4.
    function automatic logic [SEL_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                              input logic [SEL_W-1:0]   p);
        logic [SEL_W-1:0] res;
        logic [SEL_W-1:0] idx;
        logic             found;
        res   = p;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = p + SEL_W'(i);
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
`ifdef MUX_ARB_PRIO0_EN
        if (r[0]) begin
            res = '0;
        end
`endif
        return res;
    endfunction

    assign winner = pick(req, ptr);
    assign busy   = (state == ST_GRANT);

    mux4_bus #(.DW(DW)) u_bus (
        .data (data_in),
        .sel  (sel),
        .y    (mux_y)
    );

    assign out_valid = busy & req[sel];
    assign out_data  = busy ? mux_y : '0;
    assign xfer      = out_valid & out_ready;

    // Release on end of packet, abandonment, or when the hold budget is used up.
    assign release_now = busy & (~req[sel] |
                                 (xfer & (last[sel] | ((cnt + 1'b1) == HOLD_C))));

    // Grant/release sequencing; sel holds across release so the bubble cycle keeps it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sel   <= '0;
            gnt   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != '0) begin
                        state <= ST_GRANT;
                        sel   <= winner;
                        gnt   <= NUM_REQ'(1) << winner;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (release_now) begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                        cnt   <= '0;
`ifdef MUX_ARB_PRIO0_EN
                        // Requester 0 is served outside the rotation, so it leaves ptr alone.
                        if (sel != '0) begin
                            ptr <= sel + 1'b1;
                        end
`else
                        ptr   <= sel + 1'b1;
`endif
                    end else if (xfer) begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed self-checking bench for mux4_rr_arbiter
`timescale 1ns/1ps
module tb_mux4_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data_in;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  sel;
    logic [3:0]  gnt;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.DW(8), .HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .data_in   (data_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .gnt       (gnt),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; last = '0; out_ready = 1'b1;
        data_in = 32'h4433_2211;
        for (int i = 0; i < 7; i++) begin
            if (i == 2) rst_n = 1'b1;
            tick();
            n_tests++;
            if ({gnt, sel, busy, out_valid, out_data} !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: gnt=%b sel=%0d busy=%b valid=%b data=%h, expected all zero",
                         i, gnt, sel, busy, out_valid, out_data);
            end
        end
    endtask

    task automatic test_single_packet();
        logic [7:0] beat [3];
        beat[0] = 8'hA0; beat[1] = 8'hA1; beat[2] = 8'hA2;
        req = 4'b0100; data_in[16 +: 8] = beat[0];
        tick();
        for (int b = 0; b < 3; b++) begin
            data_in[16 +: 8] = beat[b];
            last = (b == 2) ? 4'b0100 : 4'b0000;
            #1;
            n_tests++;
            if ({gnt, sel, busy, out_valid, out_data} !== {4'b0100, 2'd2, 1'b1, 1'b1, beat[b]}) begin
                n_fail++;
                $display("FAIL single_beat%0d: gnt=%b sel=%0d busy=%b valid=%b data=%h, expected 0100/2/1/1/%h",
                         b, gnt, sel, busy, out_valid, out_data, beat[b]);
            end
            tick();
        end
        req = '0; last = '0;
        n_tests++;
        if ({gnt, sel, busy, out_valid} !== {4'b0000, 2'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_release: gnt=%b sel=%0d busy=%b, expected 0000/2/0", gnt, sel, busy);
        end
        // ptr must now be 3: with 0,1,3 requesting, requester 3 wins.
        tick();
        req = 4'b1011;
        tick();
        n_tests++;
        if (gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL single_ptr3: gnt=%b, expected 1000", gnt);
        end
        req = '0;
        tick();
        n_tests++;
        if ({gnt, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL abandon_release: gnt=%b busy=%b, expected 0000/0", gnt, busy);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g [5];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        req = 4'b1111; last = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (gnt !== exp_g[i]) begin
                n_fail++;
                $display("FAIL fair_grant%0d: gnt=%b, expected %b", i, gnt, exp_g[i]);
            end
            tick();
            n_tests++;
            if ({gnt, busy} !== 5'b0) begin
                n_fail++;
                $display("FAIL fair_bubble%0d: gnt=%b busy=%b, expected 0000/0", i, gnt, busy);
            end
        end
        req = '0; last = '0;
        tick();
    endtask

    task automatic test_forced_rotation();
        // ptr is 1 here; requester 1 streams without last, 3 waits.
        req = 4'b0010;
        tick();
        req = 4'b1010;
        for (int b = 1; b <= 3; b++) begin
            tick();
            n_tests++;
            if ({gnt, busy} !== {4'b0010, 1'b1}) begin
                n_fail++;
                $display("FAIL forced_hold%0d: gnt=%b busy=%b, expected 0010/1", b, gnt, busy);
            end
        end
        tick();
        n_tests++;
        if ({gnt, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL forced_release: gnt=%b busy=%b, expected 0000/0", gnt, busy);
        end
        tick();
        n_tests++;
        if ({gnt, sel} !== {4'b1000, 2'd3}) begin
            n_fail++;
            $display("FAIL forced_next: gnt=%b sel=%0d, expected 1000/3", gnt, sel);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        // ptr is 0 here.
        req = 4'b0001; out_ready = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if ({gnt, out_valid, out_data} !== {4'b0001, 1'b1, 8'h11}) begin
                n_fail++;
                $display("FAIL stall%0d: gnt=%b valid=%b data=%h, expected 0001/1/11",
                         i, gnt, out_valid, out_data);
            end
        end
        // Three beats must not hit the 4-beat budget if stalls were not counted.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_tests++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL stall_nocount: gnt=%b, expected 0001", gnt);
        end
        req = '0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abandon_valid: valid=%b, expected 0", out_valid);
        end
        tick();
        n_tests++;
        if ({gnt, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL stall_abandon: gnt=%b busy=%b, expected 0000/0", gnt, busy);
        end
    endtask

    task automatic test_priority();
        logic [3:0] first_g, second_g;
`ifdef MUX_ARB_PRIO0_EN
        first_g = 4'b0001; second_g = 4'b0100;
`else
        first_g = 4'b0100; second_g = 4'b0001;
`endif
        // ptr is 1: grant and abandon requester 1 to move ptr to 2.
        req = 4'b0010;
        tick();
        req = '0;
        tick();
        req = 4'b0101; last = 4'b1111;
        tick();
        n_tests++;
        if (gnt !== first_g) begin
            n_fail++;
            $display("FAIL prio_first: gnt=%b, expected %b", gnt, first_g);
        end
        tick();
        req = 4'b0101 & ~first_g;
        tick();
        n_tests++;
        if (gnt !== second_g) begin
            n_fail++;
            $display("FAIL prio_second: gnt=%b, expected %b", gnt, second_g);
        end
        req = '0; last = '0;
        tick();
    endtask

    task automatic test_reset_mid_packet();
        tick();
        req = 4'b0100;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++;
        if ({gnt, sel, busy, out_valid} !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_mid: gnt=%b sel=%0d busy=%b valid=%b, expected zeros",
                     gnt, sel, busy, out_valid);
        end
        // ptr back to 0 after reset: with 0 and 2 requesting, 0 wins.
        req = 4'b0101;
        tick();
        n_tests++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_ptr: gnt=%b, expected 0001", gnt);
        end
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_fairness();
        test_forced_rotation();
        test_backpressure();
        test_priority();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4:1 data mux. Four requesters compete for one output channel.
- Owns the mux select (sel[1:0]) and the one-hot grant. Grants whole packets (req/last framing) with a valid/ready handshake on the shared output.
- Sits between the four source ports and the single downstream consumer.

Parameters:
- DW, 8, data width per requester.
- HOLD_MAX, 8, maximum beats per grant before forced rotation. Legal range is 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  4  per-requester request; also acts as beat-valid while granted.
- last  in  4  per-requester end-of-packet flag, qualified by the transferred beat.
- data_in  in  4*DW  packed inputs; requester k occupies [k*DW +: DW].
- out_ready  in  1  downstream accepts the beat.
- out_valid  out  1  shared channel beat valid.
- out_data  out  DW  shared channel data (muxed).
- sel  out  2  registered mux select; equals the granted index.
- gnt  out  4  registered one-hot grant.
- busy  out  1  high in the GRANT state.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; sel=0; gnt=0; busy=0; ptr=0; beat count=0.
  - out_valid=0 and out_data=0 combinationally follow from this state.
  - Reset mid-packet drops the grant immediately. The partial packet is not resumed.
- States:
  - IDLE: no grant.
  - GRANT: one requester owns the channel.
- IDLE -> GRANT, when req != 0:
  - Winner is the first asserted req scanning ptr, ptr+1, ... mod 4.
  - sel and gnt are registered on that edge, so grant latency is 1 cycle from req.
  - With req==0, stay in IDLE.
- Outputs in GRANT:
  - out_valid = req[sel].
  - out_data = data_in[sel].
  - Transfer = out_valid & out_ready.
  - Outside GRANT: out_valid=0 and out_data=0.
- Release from GRANT to IDLE at the edge where any of the following holds:
  - (a) a transfer occurs with last[sel]=1;
  - (b) req[sel]=0 (requester abandons);
  - (c) a transfer occurs and the beat count reaches HOLD_MAX (forced rotation).
- On release:
  - ptr = sel+1 (2-bit wrap, 3 -> 0); gnt=0; beat count=0.
  - sel holds its value (do not clear it).
  - One-cycle bubble in IDLE before the next grant, even if requests are pending.
- Beat counter:
  - 8 bits; increments on each transfer in GRANT; cleared on release.
  - Comparison is count+1 == HOLD_MAX at the transfer.
- Back-pressure: out_ready=0 holds the grant indefinitely and does not count beats. Release cause (b) still applies.
- Simultaneous causes (a) and (c): single release, same result.
- The ptr update depends only on the released index, never on the release cause.
- Fairness: with all four req held high, grants rotate 0,1,2,3,0...

Optional Feature:
- Macro: MUX_ARB_PRIO0_EN.
- Defined:
  - In IDLE, req[0]=1 always wins regardless of ptr.
  - Releasing requester 0 does not update ptr, so round-robin among 1..3 is preserved.
  - No preemption of an active grant.
- Undefined: pure round-robin as above.

Decomposition:
- Package mux_arb_pkg:
  - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1;
  - NUM_REQ=4;
  - SEL_W=2;
  - CNT_W=8.
- One sub-module, mux4_bus: parameterised DW-bit 4:1 combinational mux driven by sel. It is instantiated for out_data, with the result gated by the GRANT state.
- The rotate/priority pick stays inline as a function.

Test Plan:
- Reset and idle:
  - Stimulus: rst_n=0 for 2 cycles, then req=4'b0000 for 5 cycles.
  - Required: gnt=0, sel=0, busy=0, out_valid=0, out_data=0 throughout.
- Single packet:
  - Stimulus: req[2]=1, data 8'hA0..A2, last on the 3rd beat, out_ready=1.
  - Required: gnt=4'b0100 one cycle after req; three transfers; release; ptr=3.
- Fairness:
  - Stimulus: req=4'b1111 with last=4'b1111 every beat.
  - Required: gnt sequence 0001, 0010, 0100, 1000, 0001, with an IDLE bubble between each.
- Forced rotation:
  - Stimulus: HOLD_MAX=4, req[1] streams with last=0.
  - Required: release after the 4th transfer; req[3] pending gets the next grant.
- Back-pressure and abandon:
  - Stimulus: out_ready=0 for 10 cycles; then req[sel] drops.
  - Required: beat count stays 0 during stall; release on the next edge.
- Priority (MUX_ARB_PRIO0_EN):
  - Stimulus: ptr=2, req=4'b0101.
  - Required: grant 0001, then 0100.
  - Without the macro, the same stimulus gives 0100 first.
